// File: rtl/spi_config_framer_pkg.sv
// Shared types and constants for the SPI configuration framer.
// CFG_CHECKSUM_EN (optional) adds a trailing XOR checksum byte to every frame.
package cfg_framer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    OVER    = 2'd3
  } state_e;

  localparam logic [31:0] CFG_RESET_DEFAULT = 32'hBBFC_0000;
  localparam int          FRAME_BYTES       = 4;
  localparam int          CNT_W             = 3;

endpackage

// File: rtl/spi_config_framer_xor.sv
// Running XOR of the bytes in one chip-select frame, cleared when a new frame opens.
// Only instantiated when CFG_CHECKSUM_EN is defined.
module cfg_xor_accum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = 8'h00;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/spi_config_framer.sv
// Assembles SPI bytes into a 32-bit config word, shadows it, and commits at frame_start.
// Optional macro CFG_CHECKSUM_EN: frames carry a fifth XOR checksum byte.
module spi_config_framer #(
  parameter logic [31:0] CFG_RESET   = cfg_framer_pkg::CFG_RESET_DEFAULT,
  parameter int          FRAME_BYTES = cfg_framer_pkg::FRAME_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        frame_start,
  output logic [31:0] config_out,
  output logic        config_pending,
  output logic        frame_error,
  output logic [7:0]  commit_count
);

  import cfg_framer_pkg::*;

`ifdef CFG_CHECKSUM_EN
  localparam int TOTAL_BYTES = FRAME_BYTES + 1;
`else
  localparam int TOTAL_BYTES = FRAME_BYTES;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BYTES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [31:0]       config_q, config_d;
  logic              pending_q, pending_d;
  logic              error_q, error_d;
  logic [7:0]        commits_q, commits_d;

  logic              start_frame;
  logic              take_byte;
  logic              shift_byte;
  logic              frame_ok;
  logic              load_shadow;
  logic              reject;
  logic              commit;

`ifdef CFG_CHECKSUM_EN
  logic [7:0] xor_acc;

  cfg_xor_accum u_xor_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (start_frame),
    .en_i    (take_byte),
    .data_i  (byte_data),
    .acc_o   (xor_acc)
  );

  // XOR over payload plus checksum byte is zero exactly when the checksum matches.
  assign frame_ok   = (xor_acc == 8'h00);
  assign shift_byte = take_byte && (cnt_q < CNT_W'(FRAME_BYTES));
`else
  assign frame_ok   = 1'b1;
  assign shift_byte = take_byte;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ss has priority over byte_valid in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ss) state_d = COLLECT;
      COLLECT: begin
        if (ss) begin
          state_d = IDLE;
        end else if (byte_valid && (cnt_q == LAST_IDX)) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (ss) begin
          state_d = IDLE;
        end else if (byte_valid) begin
          state_d = OVER;
        end
      end
      OVER:    if (ss) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_frame = 1'b0;
    take_byte   = 1'b0;
    load_shadow = 1'b0;
    reject      = 1'b0;
    case (state_q)
      IDLE:    start_frame = !ss;
      COLLECT: begin
        take_byte = !ss && byte_valid;
        reject    = ss;
      end
      FULL: begin
        load_shadow = ss && frame_ok;
        reject      = ss && !frame_ok;
      end
      OVER:    reject = ss;
      default: ;
    endcase
  end

  // Commit sees the pre-load shadow, so a word landing this cycle waits for the next strobe.
  always_comb begin
    commit    = frame_start && pending_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    if (start_frame) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (take_byte) begin
      cnt_d = cnt_q + 1'b1;
      if (shift_byte) begin
        asm_d = {asm_q[23:0], byte_data};
      end
    end
    shadow_d  = load_shadow ? asm_q : shadow_q;
    config_d  = commit ? shadow_q : config_q;
    commits_d = commits_q + {7'd0, commit};
    if (load_shadow) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    error_d   = reject;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      asm_q     <= '0;
      shadow_q  <= CFG_RESET;
      config_q  <= CFG_RESET;
      pending_q <= 1'b0;
      error_q   <= 1'b0;
      commits_q <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      shadow_q  <= shadow_d;
      config_q  <= config_d;
      pending_q <= pending_d;
      error_q   <= error_d;
      commits_q <= commits_d;
    end
  end

  assign config_out     = config_q;
  assign config_pending = pending_q;
  assign frame_error    = error_q;
  assign commit_count   = commits_q;

endmodule
